// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch front-end: default widths, reset PC and the
// NOP bubble that decode sees when nothing valid is queued.
package fetch_queue_pkg;

  localparam int              XLEN_DEF     = 32;
  localparam int              DEPTH_DEF    = 4;
  localparam logic [31:0]     NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0]     RESET_PC_DEF = 32'h0000_0000;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Redirect, instruction-memory and decode handshakes of the fetch queue.
// The master modport is the fetch queue itself; slave is its environment.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_inst;
  logic            dec_ready;
  logic            dec_valid;
  logic [31:0]     dec_inst;
  logic [XLEN-1:0] dec_pc;
  logic [CW-1:0]   q_count;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_inst, dec_ready,
    output imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc, q_count
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_inst, dec_ready,
    input  imem_req_valid, imem_req_addr, dec_valid, dec_inst, dec_pc, q_count
  );
endinterface

// File: rtl/fetch_queue_chk.sv
// Invariants of the fetch queue: the credit rule keeps both FIFOs from
// overflowing and the PC tracker mirrors the outstanding counter.
module fetch_queue_chk #(
  parameter int CW = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          iq_push,
  input logic          iq_pop,
  input logic          iq_full,
  input logic          pc_push,
  input logic          pc_pop,
  input logic          pc_full,
  input logic          pc_empty,
  input logic [CW-1:0] pc_count,
  input logic [CW-1:0] outstanding
);

  // Sampled each rising edge while out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(iq_push && iq_full && !iq_pop));
      assert (!(pc_push && pc_full && !pc_pop));
      assert (!(pc_pop && pc_empty));
      assert (pc_count == outstanding);
    end
  end

endmodule

// File: rtl/fetch_queue_fifo.sv
// Small synchronous FIFO used for both the instruction queue and the
// in-flight PC tracker. Flush wins over push and pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == CW'(0));
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  // A push into a full FIFO is only taken when a pop frees a slot this cycle.
  assign do_push_s = push && (!full || do_pop_s);

  // Pointers, occupancy and storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: PC generator, in-flight request tracking and
// a DEPTH-entry queue feeding decode; redirects flush and cancel fetches.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          XLEN     = XLEN_DEF,
  parameter int          DEPTH    = DEPTH_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.master bus
);
  localparam int CW = cnt_width(DEPTH);
  localparam int IW = 32 + XLEN;

  logic [XLEN-1:0] fetch_pc_r;
  logic [CW-1:0]   outstanding_r;
  logic [CW-1:0]   drop_cnt_r;
  logic [CW-1:0]   q_count_s;
  logic [CW-1:0]   pc_count_s;
  logic [CW:0]     credit_s;
  logic            req_valid_s;
  logic            accept_s;
  logic            rsp_s;
  logic            drop_rsp_s;
  logic            iq_push_s;
  logic            iq_pop_s;
  logic            iq_full_s;
  logic            iq_empty_s;
  logic            pc_full_s;
  logic            pc_empty_s;
  logic [IW-1:0]   iq_wdata_s;
  logic [IW-1:0]   iq_rdata_s;
  logic [XLEN-1:0] rsp_pc_s;

  // Queued entries plus requests still in flight may never exceed DEPTH.
  assign credit_s    = {1'b0, q_count_s} + {1'b0, outstanding_r};
  assign req_valid_s = reset && !bus.redirect_valid && (credit_s < (CW+1)'(DEPTH));
  assign accept_s    = req_valid_s && bus.imem_req_ready;
  assign rsp_s       = bus.imem_rsp_valid;
  assign drop_rsp_s  = rsp_s && (bus.redirect_valid || (drop_cnt_r != CW'(0)));
  assign iq_push_s   = rsp_s && !drop_rsp_s;
  assign iq_pop_s    = !iq_empty_s && bus.dec_ready;
  assign iq_wdata_s  = {rsp_pc_s, bus.imem_rsp_inst};

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = fetch_pc_r;
  assign bus.dec_valid      = !iq_empty_s;
  assign bus.dec_inst       = iq_empty_s ? NOP_INST : iq_rdata_s[31:0];
  assign bus.dec_pc         = iq_empty_s ? '0 : iq_rdata_s[32 +: XLEN];
  assign bus.q_count        = q_count_s;

  // PC generator, outstanding-request counter and stale-response counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r    <= XLEN'(RESET_PC);
      outstanding_r <= '0;
      drop_cnt_r    <= '0;
    end else begin
      if (bus.redirect_valid) begin
        fetch_pc_r <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      end else if (accept_s) begin
        fetch_pc_r <= fetch_pc_r + XLEN'(32'd4);
      end
      outstanding_r <= outstanding_r + CW'(accept_s) - CW'(rsp_s);
      // Everything still in flight at a redirect belongs to the old path.
      if (bus.redirect_valid) begin
        drop_cnt_r <= outstanding_r - CW'(rsp_s);
      end else if (rsp_s && (drop_cnt_r != CW'(0))) begin
        drop_cnt_r <= drop_cnt_r - CW'(1);
      end
    end
  end

  fetch_fifo #(.WIDTH(IW), .DEPTH(DEPTH)) u_inst_q (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (bus.redirect_valid),
    .push      (iq_push_s),
    .push_data (iq_wdata_s),
    .pop       (iq_pop_s),
    .pop_data  (iq_rdata_s),
    .count     (q_count_s),
    .full      (iq_full_s),
    .empty     (iq_empty_s)
  );

  // PC of each in-flight request, consumed in order by its response.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_q (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (1'b0),
    .push      (accept_s),
    .push_data (fetch_pc_r),
    .pop       (rsp_s),
    .pop_data  (rsp_pc_s),
    .count     (pc_count_s),
    .full      (pc_full_s),
    .empty     (pc_empty_s)
  );

  fetch_queue_chk #(.CW(CW)) u_chk (
    .clk         (clk),
    .reset       (reset),
    .iq_push     (iq_push_s),
    .iq_pop      (iq_pop_s && !bus.redirect_valid),
    .iq_full     (iq_full_s),
    .pc_push     (accept_s),
    .pc_pop      (rsp_s),
    .pc_full     (pc_full_s),
    .pc_empty    (pc_empty_s),
    .pc_count    (pc_count_s),
    .outstanding (outstanding_r)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed table, hand sequences for redirect/reset
// corners and a randomized run against a queue-based reference model.
module tb_fetch_queue;
  localparam int          XLEN = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic dr; logic exp_rv; logic [31:0] exp_addr;
    logic exp_dv; logic [31:0] exp_pc; int exp_qc;
  } vec_t;

  ent_t  mq[$];
  fl_t   fl[$];
  mreq_t memq[$];
  logic [31:0] m_fpc;
  logic [31:0] last_pc;
  bit    have_last;
  int    cyc;
  int    lat;
  bit    rand_lat;
  int    total = 0;
  int    bad = 0;

  logic        s_rv, s_dv;
  logic [31:0] s_addr, s_pc, s_inst;
  logic [2:0]  s_qc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_inst = 32'h0; bus.dec_ready = 1'b0;
    mq.delete(); fl.delete(); memq.delete();
    m_fpc = 32'h0; have_last = 1'b0; cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // One clock: drive inputs, sample and check against the model, advance.
  task automatic run_cycle(input logic dr, input logic rdy, input logic rv, input logic [31:0] rpc);
    logic rsp_now, e_rv, e_dv;
    logic [31:0] rsp_inst, e_pc, e_inst;
    int due;
    fl_t fe;
    rsp_now = 1'b0; rsp_inst = 32'h0;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      rsp_now = 1'b1; rsp_inst = memq[0].addr | 32'h13; memq.delete(0);
    end
    bus.dec_ready = dr; bus.imem_req_ready = rdy;
    bus.redirect_valid = rv; bus.redirect_pc = rpc;
    bus.imem_rsp_valid = rsp_now; bus.imem_rsp_inst = rsp_inst;
    #1;
    s_rv = bus.imem_req_valid; s_addr = bus.imem_req_addr; s_dv = bus.dec_valid;
    s_pc = bus.dec_pc; s_inst = bus.dec_inst; s_qc = bus.q_count;
    e_rv = !rv && (mq.size() + fl.size() < DEPTH);
    e_dv = (mq.size() > 0);
    e_pc = e_dv ? mq[0].pc : 32'h0;
    e_inst = e_dv ? mq[0].inst : NOP;
    chk("req_valid", 32'(s_rv), 32'(e_rv));
    chk("req_addr", s_addr, m_fpc);
    chk("dec_valid", 32'(s_dv), 32'(e_dv));
    chk("dec_pc", s_pc, e_pc);
    chk("dec_inst", s_inst, e_inst);
    chk("q_count", 32'(s_qc), 32'(mq.size()));
    if (s_rv && rdy) begin
      due = cyc + (rand_lat ? $urandom_range(1, 3) : lat);
      if (memq.size() > 0 && memq[$].due >= due) due = memq[$].due + 1;
      memq.push_back('{s_addr, due});
    end
    if (e_dv && dr && !rv) begin
      if (have_last) chk("seq_pc", mq[0].pc, last_pc + 32'd4);
      last_pc = mq[0].pc; have_last = 1'b1;
      mq.delete(0);
    end
    if (rsp_now && fl.size() > 0) begin
      fe = fl[0]; fl.delete(0);
      if (!rv && !fe.stale) mq.push_back('{fe.pc, rsp_inst});
    end
    if (rv) begin
      mq.delete();
      foreach (fl[i]) fl[i].stale = 1'b1;
      m_fpc = {rpc[31:2], 2'b00};
      have_last = 1'b0;
    end else if (e_rv && rdy) begin
      fl.push_back('{m_fpc, 1'b0});
      m_fpc = m_fpc + 32'd4;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  vec_t vt[18];

  initial begin
    int seen, stale;
    logic [31:0] rpc;
    logic [31:0] first_pc;

    vt[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 0};
    vt[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 0};
    vt[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 1};
    vt[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 1};
    vt[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h08, 1};
    vt[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h08, 2};
    vt[6]  = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h08, 3};
    for (int i = 7; i <= 13; i++) vt[i] = '{1'b0, 1'b0, 32'h18, 1'b1, 32'h08, 4};
    vt[14] = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h08, 4};
    vt[15] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C, 3};
    vt[16] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 2};
    vt[17] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14, 2};

    rand_lat = 1'b0; lat = 1;
    rst = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_inst = 32'h0; bus.dec_ready = 1'b0;
    #3;
    chk("rst_dec_valid", 32'(bus.dec_valid), 32'h0);
    chk("rst_dec_inst", bus.dec_inst, NOP);
    chk("rst_dec_pc", bus.dec_pc, 32'h0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("rst_q_count", 32'(bus.q_count), 32'h0);

    // Directed table: startup, saturation under stall and drain.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      run_cycle(vt[i].dr, 1'b1, 1'b0, 32'h0);
      chk("tbl_req_valid", 32'(s_rv), 32'(vt[i].exp_rv));
      chk("tbl_req_addr", s_addr, vt[i].exp_addr);
      chk("tbl_dec_valid", 32'(s_dv), 32'(vt[i].exp_dv));
      chk("tbl_dec_pc", s_pc, vt[i].exp_pc);
      chk("tbl_dec_inst", s_inst, vt[i].exp_dv ? (vt[i].exp_pc | 32'h13) : NOP);
      chk("tbl_q_count", 32'(s_qc), 32'(vt[i].exp_qc));
    end

    // Redirect with two requests in flight on 3-cycle memory.
    do_reset(); lat = 3;
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b0, 1'b1, 32'h100);
    seen = 0; stale = 0; first_pc = 32'h0;
    for (int i = 0; i < 16; i++) begin
      run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        chk("redir3_addr", s_addr, 32'h100);
        chk("redir3_q_count", 32'(s_qc), 32'h0);
      end
      if (s_dv && seen == 0) begin seen = 1; first_pc = s_pc; end
      if (s_dv && s_pc < 32'h100) stale++;
    end
    chk("redir3_seen", 32'(seen), 32'h1);
    chk("redir3_first_pc", first_pc, 32'h100);
    chk("redir3_stale", 32'(stale), 32'h0);

    // Redirect coinciding with a response and a pop; misaligned target.
    do_reset(); lat = 1;
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b1, 1'b1, 32'h101);
    chk("redirN_dec_valid", 32'(s_dv), 32'h1);
    chk("redirN_req_valid", 32'(s_rv), 32'h0);
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redirN1_q_count", 32'(s_qc), 32'h0);
    chk("redirN1_addr", s_addr, 32'h100);
    chk("redirN1_req_valid", 32'(s_rv), 32'h1);
    chk("redirN1_dec_inst", s_inst, NOP);
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redirN2_dec_valid", 32'(s_dv), 32'h0);
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redirN3_dec_valid", 32'(s_dv), 32'h1);
    chk("redirN3_dec_pc", s_pc, 32'h100);
    chk("redirN3_dec_inst", s_inst, 32'h113);

    // Randomized traffic: ready, stall, latency and occasional redirects.
    do_reset(); rand_lat = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      run_cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                ($urandom_range(0, 99) < 3), rpc);
    end
    rand_lat = 1'b0;

    // Asynchronous reset with three entries queued.
    do_reset(); lat = 1;
    repeat (4) run_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    chk("prerst_q_count", 32'(bus.q_count), 32'h3);
    #2 rst = 1'b0;
    #1;
    chk("arst_dec_valid", 32'(bus.dec_valid), 32'h0);
    chk("arst_dec_inst", bus.dec_inst, NOP);
    chk("arst_dec_pc", bus.dec_pc, 32'h0);
    chk("arst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("arst_q_count", 32'(bus.q_count), 32'h0);
    do_reset();
    run_cycle(1'b1, 1'b1, 1'b0, 32'h0);
    chk("post_rst_req_valid", 32'(s_rv), 32'h1);
    chk("post_rst_addr", s_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
